// File: rtl/div_reconstruct_seq.sv
// Reconstructs a dividend from a quotient/remainder pair: P = Q*B + R.
// The multiply is a shift-add loop retiring one divisor bit per cycle, so a
// job always takes BW CALC cycles. The unit then compares P against the
// expected dividend and checks that the remainder is in range (R < B).
// Operands enter and results leave through valid/ready handshakes.
module div_reconstruct_seq #(
  parameter int unsigned QW = 16,
  parameter int unsigned BW = 8,
  parameter int unsigned RW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [QW-1:0]   q,
  input  logic [BW-1:0]   b,
  input  logic [RW-1:0]   r,
  input  logic [QW-1:0]   a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW+BW:0]  product,
  output logic            match,
  output logic            rem_ok,
  output logic            ok
);

  // Product width. Wide enough that (2^QW-1)(2^BW-1) + 2^RW-1 cannot wrap.
  localparam int unsigned PW = QW + BW + 1;
  // Iteration counter width; at least one bit, even when BW == 1.
  localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CW-1:0] CntLast = CW'(BW - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] acc_q;        // running partial sum, seeded with R
  logic [PW-1:0] mcand_q;      // Q, shifted left one place per cycle
  logic [BW-1:0] mult_q;       // B, shifted right one place per cycle
  logic [CW-1:0] cnt_q;
  logic [QW-1:0] a_q;          // expected dividend, held for the final compare
  logic          rem_chk_q;    // remainder check, evaluated when the job is accepted

  logic [PW-1:0] product_q;
  logic          match_q;
  logic          rem_ok_q;
  logic          ok_q;

  logic [PW-1:0] acc_sum;
  logic          calc_last;
  logic          rem_chk_in;

  // Partial sum for the current cycle: add Q (already shifted) when this B bit is set.
  always_comb begin
    acc_sum    = acc_q + (mult_q[0] ? mcand_q : '0);
    calc_last  = (cnt_q == CntLast);
    rem_chk_in = (b != '0) && (PW'(r) < PW'(b));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the handshake outputs, which are decoded directly from the state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (calc_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shift-add datapath. Operands are captured on acceptance, and the results are
  // registered on the last CALC edge. Everything is held while the unit is in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      rem_chk_q <= 1'b0;
      product_q <= '0;
      match_q   <= 1'b0;
      rem_ok_q  <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            acc_q     <= PW'(r);
            mcand_q   <= PW'(q);
            mult_q    <= b;
            a_q       <= a;
            rem_chk_q <= rem_chk_in;
            cnt_q     <= '0;
          end
        end
        StCalc: begin
          acc_q   <= acc_sum;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (calc_last) begin
            product_q <= acc_sum;
            match_q   <= (acc_sum == PW'(a_q));
            rem_ok_q  <= rem_chk_q;
            ok_q      <= (acc_sum == PW'(a_q)) && rem_chk_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;
  assign match   = match_q;
  assign rem_ok  = rem_ok_q;
  assign ok      = ok_q;

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// Bench for div_reconstruct_seq. It runs a table of fixed vectors, a block of
// random jobs checked against an arithmetic model, and hand-written sequences
// for output backpressure and for a reset that arrives mid-job.
module tb_div_reconstruct_seq;

  localparam int unsigned QW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned RW = 16;
  localparam int unsigned PW = QW + BW + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] q;
  logic [BW-1:0] b;
  logic [RW-1:0] r;
  logic [QW-1:0] a;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          match;
  logic          rem_ok;
  logic          ok;

  int n_checks = 0;
  int n_fail   = 0;

  div_reconstruct_seq #(
    .QW(QW),
    .BW(BW),
    .RW(RW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q        (q),
    .b        (b),
    .r        (r),
    .a        (a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .match    (match),
    .rem_ok   (rem_ok),
    .ok       (ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] q;
    logic [BW-1:0] b;
    logic [RW-1:0] r;
    logic [QW-1:0] a;
    logic [PW-1:0] product;
    logic          match;
    logic          rem_ok;
    logic          ok;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic straight from the definition.
  task automatic model(input logic [QW-1:0] mq, input logic [BW-1:0] mb,
                       input logic [RW-1:0] mr, input logic [QW-1:0] ma,
                       output vec_t v);
    longint unsigned p;
    p         = longint'(mq) * longint'(mb) + longint'(mr);
    v.q       = mq;
    v.b       = mb;
    v.r       = mr;
    v.a       = ma;
    v.product = PW'(p);
    v.match   = (p == longint'(ma));
    v.rem_ok  = (mb != 0) && (longint'(mr) < longint'(mb));
    v.ok      = v.match && v.rem_ok;
  endtask

  // Present operands and return just after the posedge that accepts them.
  task automatic send(input logic [QW-1:0] sq, input logic [BW-1:0] sb,
                      input logic [RW-1:0] sr, input logic [QW-1:0] sa);
    int waited;
    @(negedge clk);
    q        = sq;
    b        = sb;
    r        = sr;
    a        = sa;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Count the CALC edges until out_valid rises. The result should appear after
  // the accepting edge plus BW CALC edges (BW+1 edges, counting the accept).
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        q        = '1;
        b        = '1;
        r        = '1;
        a        = '0;
        check({tag, "_in_ready_calc"}, 64'(in_ready), 64'd0);
      end
    end while (!out_valid && k < 3 * BW);
    check({tag, "_latency"}, 64'(k), 64'(BW));
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_product"},   64'(product),   64'(v.product));
    check({tag, "_match"},     64'(match),     64'(v.match));
    check({tag, "_rem_ok"},    64'(rem_ok),    64'(v.rem_ok));
    check({tag, "_ok"},        64'(ok),        64'(v.ok));
  endtask

  // Hold out_ready low for `hold` cycles, then complete the output handshake.
  task automatic release_result(input string tag, input int hold, input vec_t v);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"},    64'(out_valid), 64'd1);
      check({tag, "_hold_product"},  64'(product),   64'(v.product));
      check({tag, "_hold_ok"},       64'(ok),        64'(v.ok));
      check({tag, "_hold_in_ready"}, 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"},    64'(out_valid), 64'd0);
    check({tag, "_post_in_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    vec_t exp_v;
    vec_t v2;
    logic [QW-1:0] rq;
    logic [BW-1:0] rb;
    logic [RW-1:0] rr;
    logic [QW-1:0] ra;

    vecs[0] = '{q: 16'h1234, b: 8'h07, r: 16'h0003, a: 16'h7F6F,
                product: 25'h0007F6F, match: 1'b1, rem_ok: 1'b1, ok: 1'b1};
    vecs[1] = '{q: 16'hFFFF, b: 8'hFF, r: 16'hFFFF, a: 16'hFFFF,
                product: 25'h0FFFF00, match: 1'b0, rem_ok: 1'b0, ok: 1'b0};
    vecs[2] = '{q: 16'h0002, b: 8'h05, r: 16'h0005, a: 16'h000F,
                product: 25'h000000F, match: 1'b1, rem_ok: 1'b0, ok: 1'b0};
    vecs[3] = '{q: 16'hABCD, b: 8'h00, r: 16'h0010, a: 16'h0010,
                product: 25'h0000010, match: 1'b1, rem_ok: 1'b0, ok: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q         = '0;
    b         = '0;
    r         = '0;
    a         = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product",   64'(product),   64'd0);
    check("reset_ok",        64'(ok),        64'd0);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].a);
      wait_done($sformatf("vec%0d", i));
      check_result($sformatf("vec%0d", i), vecs[i]);
      release_result($sformatf("vec%0d", i), 0, vecs[i]);
    end

    // Backpressure: the consumer stalls 5 cycles while new operands already wait.
    // They must not be accepted until the cycle after the result handshake.
    model(16'h0321, 8'h0D, 16'h0004, 16'h28AD, exp_v);
    model(16'h00FF, 8'h10, 16'h000F, 16'h0FFF, v2);
    send(exp_v.q, exp_v.b, exp_v.r, exp_v.a);
    wait_done("bp");
    check_result("bp", exp_v);
    q        = v2.q;
    b        = v2.b;
    r        = v2.r;
    a        = v2.a;
    in_valid = 1'b1;
    release_result("bp", 5, exp_v);
    // in_valid is still high, so the next posedge is the accepting edge.
    @(posedge clk);
    #1;
    wait_done("bp_next");
    check_result("bp_next", v2);
    release_result("bp_next", 0, v2);

    // A reset during the 4th CALC cycle aborts the job and leaves no trace.
    send(16'h1111, 8'h22, 16'h0001, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_product",   64'(product),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BW + 4) begin
      @(negedge clk);
      if (out_valid) check("abort_spurious_valid", 64'(out_valid), 64'd0);
    end
    model(16'h0042, 8'h03, 16'h0002, 16'h00C8, exp_v);
    send(exp_v.q, exp_v.b, exp_v.r, exp_v.a);
    wait_done("after_abort");
    check_result("after_abort", exp_v);
    release_result("after_abort", 0, exp_v);

    // Random jobs. Half are built as a real division so match and rem_ok come out true.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        ra = QW'($urandom);
        rb = BW'($urandom_range(1, (1 << BW) - 1));
        rq = ra / QW'(rb);
        rr = RW'(ra % QW'(rb));
      end else begin
        rq = QW'($urandom);
        rb = ($urandom_range(0, 5) == 0) ? '0 : BW'($urandom);
        rr = ($urandom_range(0, 1) == 0) ? RW'($urandom_range(0, 300)) : RW'($urandom);
        ra = QW'($urandom);
      end
      model(rq, rb, rr, ra, exp_v);
      send(rq, rb, rr, ra);
      wait_done($sformatf("rnd%0d", i));
      check_result($sformatf("rnd%0d", i), exp_v);
      release_result($sformatf("rnd%0d", i), $urandom_range(0, 2), exp_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
